// File: rtl/mips_cpu_muldiv_hilo_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface mips_cpu_muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] read_hi;
    logic [WIDTH-1:0] read_lo;

    modport master (output start, op, op_a, op_b, input busy, done, read_hi, read_lo);
    modport slave  (input start, op, op_a, op_b, output busy, done, read_hi, read_lo);
endinterface

// File: rtl/mips_cpu_muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO writes.
// Optional MULDIV_FAST_MULT_EN: single-cycle combinational MULT/MULTU.
module mips_cpu_muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_cpu_muldiv_hilo_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi, lo, mag_a, mag_b;
    logic [2*WIDTH-1:0] acc;
    logic               is_div, neg_q, neg_r, div0, done_q;

    // Even opcodes among 000..011 are the signed variants.
    logic             sgn_op, a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    assign sgn_op = ~bus.op[0];
    assign a_neg  = sgn_op & bus.op_a[WIDTH-1];
    assign b_neg  = sgn_op & bus.op_b[WIDTH-1];
    assign abs_a  = a_neg ? -bus.op_a : bus.op_a;
    assign abs_b  = b_neg ? -bus.op_b : bus.op_b;

    // Multiply step: conditional add of multiplicand into upper half, then shift right.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);

    // Restoring divide step: upper half is the partial remainder, lower half shifts
    // dividend bits out and quotient bits in.
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    assign div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge  = div_sh >= {1'b0, mag_b};
    assign div_sub = div_sh[WIDTH-1:0] - mag_b;

    // Divide-by-zero keeps the all-ones quotient; the remainder path restores op_a.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;
    assign prod_fix = neg_q ? -acc : acc;
    assign q_fix    = (neg_q && !div0) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_mag, fast_prod;
    assign fast_mag  = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
    assign fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MTHI) hi <= bus.op_a;
                        else if (bus.op == OP_MTLO) lo <= bus.op_a;
`ifdef MULDIV_FAST_MULT_EN
                        else if (!bus.op[2] && !bus.op[1]) begin
                            {hi, lo} <= fast_prod;
                            done_q   <= 1'b1;
                        end
`endif
                        else if (!bus.op[2]) begin
                            state  <= S_PREP;
                            is_div <= bus.op[1];
                            mag_a  <= abs_a;
                            mag_b  <= abs_b;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            div0   <= (bus.op_b == '0);
                        end
                    end
                end
                S_PREP: begin
                    acc   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    cnt   <= '0;
                    state <= S_CALC;
                end
                S_CALC: begin
                    if (is_div)
                        acc <= {(div_ge ? div_sub : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
                    else
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) state <= S_FIX;
                end
                default: begin
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = done_q;
    assign bus.read_hi = hi;
    assign bus.read_lo = lo;
endmodule

// File: tb/tb_mips_cpu_muldiv_hilo.sv
// Randomised and directed bench for mips_cpu_muldiv_hilo against an arithmetic reference model.
module tb_mips_cpu_muldiv_hilo;
    localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;

    localparam logic [2:0]  D_OP [5] = '{MULT, MULTU, DIV, DIVU, DIV};
    localparam logic [31:0] D_A  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'h80000000};
    localparam logic [31:0] D_B  [5] = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF};
    localparam logic [31:0] D_HI [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h64, 32'h0};
    localparam logic [31:0] D_LO [5] = '{32'hFFFFFFEB, 32'h1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_cpu_muldiv_hilo_if #(.WIDTH(W)) bus();
    mips_cpu_muldiv_hilo #(.WIDTH(W)) dut (.clk(clk), .reset(rst_n), .bus(bus));

    int n_pass = 0;
    int n_chk  = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q, m;
        logic [63:0] r;
        case (o)
            MULT:  r = sa * sb;
            MULTU: r = {32'h0, a} * {32'h0, b};
            DIV: begin
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            DIVU:  r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int exp_busy(input logic [2:0] o);
        return (FAST && o < 3'd2) ? 0 : W + 2;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(15));
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Issues one mul/div at the current negedge; returns at the negedge of the done cycle.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int nb, output bit got);
        bus.start = 1'b1; bus.op = o; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
        nb = 0; got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (bus.done) got = 1'b1;
            else begin
                if (bus.busy) nb++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = '0; bus.op_a = '0; bus.op_b = '0;
        rst_n = 1'b0;
        #12;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_chk++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
        n_chk++; if (bus.read_hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", bus.read_hi); else n_pass++;
        n_chk++; if (bus.read_lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", bus.read_lo); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int nb; bit got;
        for (int i = 0; i < 5; i++) begin
            do_op(D_OP[i], D_A[i], D_B[i], nb, got);
            n_chk++; if (!got) $display("FAIL dir%0d_done: no done pulse", i); else n_pass++;
            n_chk++; if (nb !== exp_busy(D_OP[i])) $display("FAIL dir%0d_busy: got %0d want %0d", i, nb, exp_busy(D_OP[i])); else n_pass++;
            n_chk++; if (bus.busy !== 1'b0) $display("FAIL dir%0d_busy_at_done: got %b want 0", i, bus.busy); else n_pass++;
            n_chk++; if (bus.read_hi !== D_HI[i]) $display("FAIL dir%0d_hi: got %h want %h", i, bus.read_hi, D_HI[i]); else n_pass++;
            n_chk++; if (bus.read_lo !== D_LO[i]) $display("FAIL dir%0d_lo: got %h want %h", i, bus.read_lo, D_LO[i]); else n_pass++;
            m_hi = D_HI[i]; m_lo = D_LO[i];
        end
        @(negedge clk);
        n_chk++; if (bus.done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", bus.done); else n_pass++;
        n_chk++; if ({bus.read_hi, bus.read_lo} !== {m_hi, m_lo}) $display("FAIL hold_after_done: got %h%h want %h%h", bus.read_hi, bus.read_lo, m_hi, m_lo); else n_pass++;
    endtask

    task automatic test_mtx();
        bus.start = 1'b1; bus.op = MTHI; bus.op_a = 32'h12345678;
        @(negedge clk);
        m_hi = 32'h12345678;
        n_chk++; if ({bus.read_hi, bus.read_lo} !== {m_hi, m_lo}) $display("FAIL mthi: got %h%h want %h%h", bus.read_hi, bus.read_lo, m_hi, m_lo); else n_pass++;
        n_chk++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL mthi_flags: got %b want 00", {bus.busy, bus.done}); else n_pass++;
        bus.op = MTLO; bus.op_a = 32'h9ABCDEF0;
        @(negedge clk);
        m_lo = 32'h9ABCDEF0;
        n_chk++; if ({bus.read_hi, bus.read_lo} !== {m_hi, m_lo}) $display("FAIL mtlo: got %h%h want %h%h", bus.read_hi, bus.read_lo, m_hi, m_lo); else n_pass++;
        n_chk++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL mtlo_flags: got %b want 00", {bus.busy, bus.done}); else n_pass++;
        bus.op = 3'b110; bus.op_a = $urandom; bus.op_b = $urandom;
        @(negedge clk);
        bus.op = 3'b111;
        @(negedge clk);
        bus.start = 1'b0;
        n_chk++; if ({bus.read_hi, bus.read_lo} !== {m_hi, m_lo}) $display("FAIL nop_ops: got %h%h want %h%h", bus.read_hi, bus.read_lo, m_hi, m_lo); else n_pass++;
        n_chk++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL nop_flags: got %b want 00", {bus.busy, bus.done}); else n_pass++;
    endtask

    task automatic test_ignore_busy();
        int nb = 0; bit got = 1'b0;
        bus.start = 1'b1; bus.op = DIVU; bus.op_a = 32'd50; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (bus.done) got = 1'b1;
            else begin
                if (bus.busy) nb++;
                bus.start = (nb == 5);
                bus.op = MTLO; bus.op_a = 32'hDEAD;
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        m_hi = 32'd1; m_lo = 32'd7;
        n_chk++; if (!got) $display("FAIL ignore_done: no done pulse"); else n_pass++;
        n_chk++; if (nb !== W + 2) $display("FAIL ignore_busy_len: got %0d want %0d", nb, W + 2); else n_pass++;
        n_chk++; if ({bus.read_hi, bus.read_lo} !== {m_hi, m_lo}) $display("FAIL ignore_result: got %h%h want %h%h", bus.read_hi, bus.read_lo, m_hi, m_lo); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.read_lo !== m_lo) $display("FAIL ignore_no_queue: got %h want %h", bus.read_lo, m_lo); else n_pass++;
    endtask

    task automatic test_random();
        int nb; bit got;
        logic [2:0] o; logic [31:0] a, b; logic [63:0] e;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(3)); a = pick(); b = pick();
            e = model(o, a, b);
            do_op(o, a, b, nb, got);
            n_chk++; if (!got) $display("FAIL rnd%0d_done: no done pulse op %0d", i, o); else n_pass++;
            n_chk++; if (nb !== exp_busy(o)) $display("FAIL rnd%0d_busy: got %0d want %0d", i, nb, exp_busy(o)); else n_pass++;
            n_chk++; if ({bus.read_hi, bus.read_lo} !== e) $display("FAIL rnd%0d_result op %0d a %h b %h: got %h%h want %h", i, o, a, b, bus.read_hi, bus.read_lo, e); else n_pass++;
            {m_hi, m_lo} = e;
        end
    endtask

    task automatic test_back_to_back();
        int nb; bit got;
        logic [63:0] e;
        do_op(MULTU, 32'hDEADBEEF, 32'h12345, nb, got);
        {m_hi, m_lo} = model(MULTU, 32'hDEADBEEF, 32'h12345);
        e = model(DIVU, 32'hCAFEF00D, 32'h1234);
        do_op(DIVU, 32'hCAFEF00D, 32'h1234, nb, got);
        n_chk++; if (!got || nb !== W + 2) $display("FAIL b2b_accept: done %b busy %0d want 1 %0d", got, nb, W + 2); else n_pass++;
        n_chk++; if ({bus.read_hi, bus.read_lo} !== e) $display("FAIL b2b_result: got %h%h want %h", bus.read_hi, bus.read_lo, e); else n_pass++;
        {m_hi, m_lo} = e;
        bus.start = 1'b1; bus.op = MTHI; bus.op_a = 32'h0BADF00D;
        @(negedge clk);
        bus.start = 1'b0;
        m_hi = 32'h0BADF00D;
        n_chk++; if ({bus.read_hi, bus.read_lo} !== {m_hi, m_lo}) $display("FAIL b2b_mthi: got %h%h want %h%h", bus.read_hi, bus.read_lo, m_hi, m_lo); else n_pass++;
    endtask

    task automatic test_reset_midop();
        int nb; bit got;
        bus.start = 1'b1; bus.op = MULT; bus.op_a = 32'd5; bus.op_b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL midreset_flags: got %b want 00", {bus.busy, bus.done}); else n_pass++;
        n_chk++; if ({bus.read_hi, bus.read_lo} !== 64'h0) $display("FAIL midreset_hilo: got %h%h want 0", bus.read_hi, bus.read_lo); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if ({bus.busy, bus.done, bus.read_hi, bus.read_lo} !== 66'h0) $display("FAIL midreset_no_trace: got busy %b done %b %h%h", bus.busy, bus.done, bus.read_hi, bus.read_lo); else n_pass++;
        do_op(MULT, 32'd2, 32'd3, nb, got);
        n_chk++; if (!got || nb !== exp_busy(MULT)) $display("FAIL postreset_timing: done %b busy %0d want 1 %0d", got, nb, exp_busy(MULT)); else n_pass++;
        n_chk++; if ({bus.read_hi, bus.read_lo} !== 64'd6) $display("FAIL postreset_result: got %h%h want 6", bus.read_hi, bus.read_lo); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mtx();
        test_ignore_busy();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mips_cpu_muldiv_hilo.md
Name: mips_cpu_muldiv_hilo

Overview:
Parametrised multi-cycle multiply/divide unit that owns the HI/LO architectural registers. It executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) and the MTHI/MTLO writes. It sits beside the ALU in the execute stage. The pipeline stalls on `busy` before MFHI/MFLO or before issuing a new mul/div.

Parameters:
WIDTH, 32, operand and HI/LO register width; must be ≥ 4 and even.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request strobe; sampled only when busy=0.
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
op_a  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
op_b  input  WIDTH  rt operand: multiplier or divisor.
busy  output  1  mul/div in progress; HI/LO hold their old values.
done  output  1  one-cycle pulse: the new mul/div result is visible on read_hi/read_lo.
read_hi  output  WIDTH  current HI.
read_lo  output  WIDTH  current LO.

Behaviour:
- Reset (reset=0), immediate and asynchronous: HI=0, LO=0, busy=0, done=0, FSM=IDLE, internal accumulators cleared. Applies mid-operation; the aborted operation leaves no trace.
- read_hi/read_lo are driven directly from the registers, with zero read latency.
- Acceptance: start=1 while state IDLE at rising edge E0.
  - start while busy=1 is ignored entirely (no queueing).
  - op 110/111 is ignored.
- MTHI/MTLO at E0: HI (or LO) <= op_a at E0. The other register is unchanged, busy stays 0, done stays 0.
- Mul/div FSM:
  - IDLE -> PREP at E0: latch operands. For signed ops, take absolute values and record the result signs (product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa).
  - PREP -> CALC: 1 cycle.
  - CALC runs exactly WIDTH cycles via a counter 0..WIDTH-1.
    - Multiply: shift-add into a 2*WIDTH-bit accumulator.
    - Divide: restoring shift-subtract, one quotient bit per cycle.
  - CALC -> FIX when the counter reaches WIDTH-1.
  - FIX: apply two's-complement sign correction, then write HI/LO on the exiting edge. FIX -> IDLE.
- Timing:
  - busy=1 for exactly WIDTH+2 cycles, edges E0..E0+WIDTH+2.
  - HI/LO update at edge E0+WIDTH+2.
  - done=1 for the single cycle after that edge, with busy=0 in the same cycle.
  - A new start in the done cycle is accepted.
- Results:
  - Multiply: {HI,LO} = full 2*WIDTH-bit product. Signed for MULT, unsigned for MULTU.
  - Divide: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
- Divide by zero, both DIV and DIVU: LO = all ones, HI = op_a. Full latency, done still pulses.
- Signed overflow (DIV, op_a = most-negative, op_b = -1): LO = most-negative, HI = 0.
- Operand inputs may change after E0; only the latched values are used.
- start and op are don't-care while busy=1.

Optional Feature:
MULDIV_FAST_MULT_EN:
- Defined: MULT/MULTU use a combinational WIDTH×WIDTH multiplier.
  - HI/LO are written at the accepting edge E0.
  - busy never asserts; done pulses in the cycle after E0.
  - DIV/DIVU behave as without the macro.
- Undefined: all four ops use the iterative path above, with WIDTH+2 busy cycles.

Test Plan:
- Reset then MULT op_a=0xFFFFFFFD (-3), op_b=7 -> busy high 34 cycles, then done=1 with HI=0xFFFFFFFF, LO=0xFFFFFFEB. With MULDIV_FAST_MULT_EN the same result appears 1 cycle after E0 and busy stays 0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
- MTHI op_a=0x12345678, then MTLO op_a=0x9ABCDEF0 on the next cycle -> HI/LO updated one edge each, busy/done never assert.
- Start DIVU 50/7 and pulse start with MTLO 0xDEAD at cycle 5 -> MTLO ignored; result LO=7, HI=1 after 34 cycles. Back-to-back start in the done cycle is accepted.
- Start MULT 5×5 and drive reset=0 at cycle 10 (asynchronous, mid-cycle) -> HI=LO=0, busy=0, done=0 immediately. After release, MULT 2×3 gives LO=6, HI=0.
